// File: rtl/sad_pkg.sv
// Shared definitions for the sub-pixel SAD engine: position codes, tie-break order, width helper.
package sad_pkg;

    typedef enum logic [2:0] {
        POS_RQ = 3'd0,
        POS_RH = 3'd1,
        POS_F  = 3'd2,
        POS_LH = 3'd3,
        POS_LQ = 3'd4
    } pos_e;

    localparam int NUM_POS = 5;

    // Entry 0 has the highest priority when block SADs tie.
    localparam logic [NUM_POS-1:0][2:0] TIE_ORDER = {POS_RH, POS_LH, POS_RQ, POS_LQ, POS_F};

    function automatic int sad_w(input int npix, input int rows, input int pix_w);
        return pix_w + $clog2((npix - 2) * rows);
    endfunction

endpackage

// File: rtl/sad_subpel_row.sv
// One filter/ref row in, five row SADs over the inner pixels out. PIPE=1 places the abs-diff
// (S1) and row-sum (S2) registers inside. SAD_SUBPEL_ROUND_EN selects round-half-up interpolation.
module sad_subpel_row
    import sad_pkg::*;
#(
    parameter int NPIX  = 8,
    parameter int PIX_W = 8,
    parameter int SAD_W = 14,
    parameter bit PIPE  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NPIX*PIX_W-1:0]    filter_pix,
    input  logic [NPIX*PIX_W-1:0]    ref_pix,
    output logic [NUM_POS*SAD_W-1:0] row_sad
);

    localparam int NIN = NPIX - 2;
    localparam int HW  = PIX_W + 1;
    localparam int QW  = PIX_W + 2;
`ifdef SAD_SUBPEL_ROUND_EN
    localparam int RND_H = 1;
    localparam int RND_Q = 2;
`else
    localparam int RND_H = 0;
    localparam int RND_Q = 0;
`endif

    logic [NUM_POS*NIN*PIX_W-1:0] ad_d;
    logic [NUM_POS*NIN*PIX_W-1:0] ad_q;
    logic [NUM_POS*SAD_W-1:0]     sum_d;
    logic [NUM_POS*SAD_W-1:0]     sum_q;

    // Edge reference pixels have no SAD contribution.
    logic ref_edge_unused;
    assign ref_edge_unused = ^{ref_pix[PIX_W-1:0], ref_pix[NPIX*PIX_W-1 -: PIX_W]};

    genvar gi, gj;
    generate
        for (gi = 0; gi < NIN; gi++) begin : g_pix
            logic [PIX_W-1:0]         fm;
            logic [PIX_W-1:0]         fc;
            logic [PIX_W-1:0]         fp;
            logic [PIX_W-1:0]         rc;
            logic [NUM_POS*PIX_W-1:0] interp;

            assign fm = filter_pix[gi*PIX_W +: PIX_W];
            assign fc = filter_pix[(gi+1)*PIX_W +: PIX_W];
            assign fp = filter_pix[(gi+2)*PIX_W +: PIX_W];
            assign rc = ref_pix[(gi+1)*PIX_W +: PIX_W];

            // Sums are widened before the shift so no carry is lost.
            assign interp[int'(POS_F)*PIX_W +: PIX_W]  = fc;
            assign interp[int'(POS_LH)*PIX_W +: PIX_W] =
                PIX_W'((HW'(fm) + HW'(fc) + HW'(RND_H)) >> 1);
            assign interp[int'(POS_RH)*PIX_W +: PIX_W] =
                PIX_W'((HW'(fc) + HW'(fp) + HW'(RND_H)) >> 1);
            assign interp[int'(POS_LQ)*PIX_W +: PIX_W] =
                PIX_W'((QW'(fm) + QW'(fc) + (QW'(fc) << 1) + QW'(RND_Q)) >> 2);
            assign interp[int'(POS_RQ)*PIX_W +: PIX_W] =
                PIX_W'((QW'(fp) + QW'(fc) + (QW'(fc) << 1) + QW'(RND_Q)) >> 2);

            for (gj = 0; gj < NUM_POS; gj++) begin : g_pos
                logic [PIX_W:0] diff;
                assign diff = {1'b0, rc} - {1'b0, interp[gj*PIX_W +: PIX_W]};
                assign ad_d[(gj*NIN + gi)*PIX_W +: PIX_W] =
                    diff[PIX_W] ? (~diff[PIX_W-1:0] + PIX_W'(1)) : diff[PIX_W-1:0];
            end
        end
    endgenerate

    always_comb begin
        sum_d = '0;
        for (int p = 0; p < NUM_POS; p++) begin
            for (int i = 0; i < NIN; i++) begin
                sum_d[p*SAD_W +: SAD_W] = sum_d[p*SAD_W +: SAD_W]
                                        + SAD_W'(ad_q[(p*NIN + i)*PIX_W +: PIX_W]);
            end
        end
    end

    generate
        if (PIPE) begin : g_pipe
            always_ff @(posedge clk) begin
                if (rst) begin
                    ad_q  <= '0;
                    sum_q <= '0;
                end else if (en) begin
                    ad_q  <= ad_d;
                    sum_q <= sum_d;
                end
            end
        end else begin : g_comb
            assign ad_q  = ad_d;
            assign sum_q = sum_d;
        end
    endgenerate

    assign row_sad = sum_q;

endmodule

// File: rtl/sad_subpel_accum.sv
// Sub-pixel SAD engine top: handshake, row counter, block accumulation, best-position pick.
// Define SAD_SUBPEL_ROUND_EN for round-half-up interpolation (applied in sad_subpel_row).
module sad_subpel_accum
    import sad_pkg::*;
#(
    parameter int  NPIX  = 8,
    parameter int  PIX_W = 8,
    parameter int  ROWS  = 8,
    localparam int SAD_W = sad_w(NPIX, ROWS, PIX_W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NPIX*PIX_W-1:0] filter_pix,
    input  logic [NPIX*PIX_W-1:0] ref_pix,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [5*SAD_W-1:0]    sad,
    output logic [2:0]            best_idx,
    output logic [SAD_W-1:0]      best_sad
);

    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    logic en;
    logic fire;

    logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
    logic s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
    logic s2_valid_q, s2_valid_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;

    logic [NUM_POS-1:0][SAD_W-1:0] row_sad;
    logic [NUM_POS-1:0][SAD_W-1:0] acc_q, acc_d;
    logic [NUM_POS-1:0][SAD_W-1:0] sad_q, sad_d;
    logic                          out_valid_q, out_valid_d;
    logic [2:0]                    best_idx_q, best_idx_d;
    logic [SAD_W-1:0]              best_sad_q, best_sad_d;
    logic [2:0]                    pick_idx;
    logic [SAD_W-1:0]              pick_sad;

    // A pending, unconsumed result freezes everything, counter included.
    assign en       = !(out_valid_q && !out_ready);
    assign in_ready = en;
    assign fire     = in_valid && en;

    sad_subpel_row #(
        .NPIX  (NPIX),
        .PIX_W (PIX_W),
        .SAD_W (SAD_W),
        .PIPE  (1'b1)
    ) u_row (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .filter_pix (filter_pix),
        .ref_pix    (ref_pix),
        .row_sad    (row_sad)
    );

    always_comb begin
        acc_d = acc_q;
        if (en && s2_valid_q) begin
            for (int p = 0; p < NUM_POS; p++) begin
                acc_d[p] = s2_first_q ? row_sad[p] : acc_q[p] + row_sad[p];
            end
        end
    end

    // Scan in tie order; only a strictly smaller SAD displaces the current pick.
    always_comb begin
        pick_idx = TIE_ORDER[0];
        pick_sad = acc_d[TIE_ORDER[0]];
        for (int k = 1; k < NUM_POS; k++) begin
            if (acc_d[TIE_ORDER[k]] < pick_sad) begin
                pick_idx = TIE_ORDER[k];
                pick_sad = acc_d[TIE_ORDER[k]];
            end
        end
    end

    always_comb begin
        row_cnt_d   = row_cnt_q;
        s1_valid_d  = s1_valid_q;
        s1_first_d  = s1_first_q;
        s1_last_d   = s1_last_q;
        s2_valid_d  = s2_valid_q;
        s2_first_d  = s2_first_q;
        s2_last_d   = s2_last_q;
        out_valid_d = out_valid_q;
        sad_d       = sad_q;
        best_idx_d  = best_idx_q;
        best_sad_d  = best_sad_q;
        if (en) begin
            s1_valid_d = fire;
            s1_first_d = (row_cnt_q == '0);
            s1_last_d  = (row_cnt_q == LAST_ROW);
            if (fire) begin
                row_cnt_d = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + CNT_W'(1);
            end
            s2_valid_d  = s1_valid_q;
            s2_first_d  = s1_first_q;
            s2_last_d   = s1_last_q;
            // en high means any shown result is being taken this cycle.
            out_valid_d = s2_valid_q && s2_last_q;
            if (s2_valid_q && s2_last_q) begin
                sad_d      = acc_d;
                best_idx_d = pick_idx;
                best_sad_d = pick_sad;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            sad_q       <= '0;
            best_idx_q  <= POS_F;
            best_sad_q  <= '0;
        end else begin
            row_cnt_q   <= row_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s2_valid_q  <= s2_valid_d;
            s2_first_q  <= s2_first_d;
            s2_last_q   <= s2_last_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            sad_q       <= sad_d;
            best_idx_q  <= best_idx_d;
            best_sad_q  <= best_sad_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sad       = sad_q;
    assign best_idx  = best_idx_q;
    assign best_sad  = best_sad_q;

endmodule
